up_bus_master: RTL and testbench
================================

Name: up_bus_master

Overview:
- Initiator (master) end of the team's up-side register bus: up_wreq/up_waddr/up_wdata/up_wack and up_rreq/up_raddr/up_rdata/up_rack.
- Accepts one register command at a time on a valid/ready command port and issues a single-cycle request on the bus. It then waits for the matching ack, or for a timeout, and returns a result on a valid/ready response port.
- Drives any up-bus register block (e.g. channel block register files) from a sequencer, a test harness or a soft controller.

Parameters:
- TIMEOUT_CYCLES, 256: cycles spent in WAIT without an ack before the transaction fails. Legal range 1..65535.
- ADDR_W, 9: up-bus address width.

Ports:
- up_clk, input, 1: single clock.
- up_rstn, input, 1: reset, asynchronous, active-low.
- cmd_valid, input, 1: command present.
- cmd_ready, output, 1: block can accept a command.
- cmd_write, input, 1: 1 = write, 0 = read.
- cmd_addr, input, ADDR_W: register address.
- cmd_wdata, input, 32: write data (ignored for reads).
- rsp_valid, output, 1: response present.
- rsp_ready, input, 1: consumer takes the response.
- rsp_write, output, 1: echo of cmd_write.
- rsp_rdata, output, 32: read data; 0 for writes; 32'hdeadbeef on timeout.
- rsp_err, output, 1: 1 = timeout.
- up_wreq, output, 1: write request pulse.
- up_waddr, output, ADDR_W: write address.
- up_wdata, output, 32: write data.
- up_wack, input, 1: write acknowledge.
- up_rreq, output, 1: read request pulse.
- up_raddr, output, ADDR_W: read address.
- up_rdata, input, 32: read data, valid while up_rack=1.
- up_rack, input, 1: read acknowledge.
- busy, output, 1: state != IDLE.
- timeout_count, output, 16: saturating count of timed-out transactions.
- stray_ack_count, output, 16: saturating count of acks seen outside REQ/WAIT.

Behaviour:
- Reset: asynchronous and active-low; the clock is up_clk and the reset is up_rstn. Every output register clears to 0 and the state goes to IDLE. Asserting reset mid-transaction drops the request at once; no response is produced for it.
- States: IDLE, REQ, WAIT, RESP.
  - IDLE: cmd_ready=1. On cmd_valid, capture write/addr/wdata and go to REQ.
  - REQ: lasts exactly 1 cycle. up_wreq=1 if the command is a write, otherwise up_rreq=1; the other request stays 0. Go to WAIT, or straight to RESP if the matching ack is already high this cycle.
  - WAIT: wait_cnt is cleared in REQ and increments every cycle spent in WAIT.
    - Matching ack (up_wack for a write, up_rack for a read): go to RESP. For a read, rsp_rdata <= up_rdata sampled in the ack cycle.
    - No ack when wait_cnt == TIMEOUT_CYCLES-1: go to RESP with rsp_err=1 and rsp_rdata=32'hdeadbeef; timeout_count increments (saturating).
    - The non-matching ack is ignored in WAIT and counted as stray.
  - RESP: rsp_valid=1, with rsp_* stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
- cmd_ready is asserted only in IDLE, so a new command cannot be accepted in the same cycle a response retires.
- up_waddr/up_raddr/up_wdata: registered from the command, held from REQ until the next command. Their reset value is 0.
- Latencies:
  - Handshake at cycle 0 puts the request on the bus at cycle 1.
  - Ack at cycle k gives rsp_valid at k+1.
  - With no ack, rsp_valid rises at cycle 2+TIMEOUT_CYCLES.
- An ack that arrives after a timeout is not matched to any transaction; it increments stray_ack_count. Both counters saturate at 16'hffff.

Decomposition:
- Package up_bus_pkg holds:
  - the state enum (IDLE/REQ/WAIT/RESP);
  - UP_TIMEOUT_DATA = 32'hdeadbeef;
  - the default ADDR_W.
- One sub-module, up_bus_satcnt: a 16-bit saturating counter with inc input and async active-low reset. It is instantiated twice.

Test Plan:
- Write with ack: cmd write addr 9'd1, data 32'h1e, handshake at cycle 0. Required: up_wreq=1 only at cycle 1 with up_waddr=1 and up_wdata=32'h1e. Responder drives up_wack at cycle 4; rsp_valid rises at cycle 5 with rsp_err=0, rsp_rdata=0, rsp_write=1.
- Read with ack: read addr 9'd0; responder drives up_rack with up_rdata=32'h00020002 three cycles after up_rreq. Required: rsp_rdata=32'h00020002, rsp_err=0, and up_wreq never asserted.
- Timeout: TIMEOUT_CYCLES=8, read addr 9'd5 with no ack. Required: rsp_valid at cycle 10 with rsp_err=1, rsp_rdata=32'hdeadbeef, timeout_count=1. A late up_rack at cycle 12 makes stray_ack_count=1.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid. Required: rsp_* stable throughout, cmd_ready=0; retire on rsp_ready, with cmd_ready=1 on the following cycle.
- Stray and wrong-type ack: up_wack pulsed in IDLE, then up_wack during a read's WAIT. Required: stray_ack_count=2, with no response until up_rack arrives.
- Reset mid-WAIT: assert up_rstn=0 during WAIT. Required: every output is 0 without waiting for a clock edge; after release the state is IDLE with cmd_ready=1 and both counters at 0.

Source files
------------

// File: rtl/up_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : up_bus_pkg
// Brief    : Shared types and constants for the up-bus initiator.
// Revision : 1.0 - initial release
// ============================================================================
package up_bus_pkg;

   // Transaction phases of the initiator
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RESP = 2'd3
   } up_state_t;

   // Read data returned when a transaction times out
   localparam logic [31:0] UP_TIMEOUT_DATA = 32'hdeadbeef;

   // Default up-bus address width
   localparam int UP_ADDR_W = 9;

endpackage
`default_nettype wire

// File: rtl/up_bus_satcnt.sv
`default_nettype none
// ============================================================================
// Module   : up_bus_satcnt
// Brief    : 16-bit event counter that sticks at all-ones.
// Revision : 1.0 - initial release
// ============================================================================
module up_bus_satcnt (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_inc,
   output logic [15:0] o_count
);

   localparam logic [15:0] c_MAX = 16'hffff;

   logic [15:0] r_count;

   // Count one event per cycle, holding at the maximum once reached
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_inc && (r_count != c_MAX)) begin
         r_count <= r_count + 16'd1;
      end
   end

   assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/up_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : up_bus_master
// Brief    : Up-bus initiator. Takes one command at a time, pulses the bus
//            request, waits for the matching ack or a timeout and returns a
//            response on a valid/ready port.
// Revision : 1.0 - initial release
// ============================================================================
module up_bus_master
   import up_bus_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int          ADDR_W         = UP_ADDR_W
) (
   input  logic              up_clk,
   input  logic              up_rstn,
   // command port
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   // response port
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_write,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err,
   // up-bus
   output logic              up_wreq,
   output logic [ADDR_W-1:0] up_waddr,
   output logic [31:0]       up_wdata,
   input  logic              up_wack,
   output logic              up_rreq,
   output logic [ADDR_W-1:0] up_raddr,
   input  logic [31:0]       up_rdata,
   input  logic              up_rack,
   // status
   output logic              busy,
   output logic [15:0]       timeout_count,
   output logic [15:0]       stray_ack_count
);

   // Value of the WAIT counter on the last cycle before giving up
   localparam logic [15:0] c_TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   up_state_t         r_state;
   logic              r_write;
   logic [15:0]       r_wait_cnt;
   logic              r_cmd_ready;
   logic              r_busy;
   logic              r_rsp_valid;
   logic              r_rsp_write;
   logic [31:0]       r_rsp_rdata;
   logic              r_rsp_err;
   logic              r_up_wreq;
   logic              r_up_rreq;
   logic [ADDR_W-1:0] r_up_waddr;
   logic [ADDR_W-1:0] r_up_raddr;
   logic [31:0]       r_up_wdata;

   logic              w_active;
   logic              w_match;
   logic              w_other;
   logic              w_timeout;
   logic              w_stray;
   logic [31:0]       w_ok_rdata;

   // Ack classification against the transaction in flight
   assign w_active   = (r_state == ST_REQ) || (r_state == ST_WAIT);
   assign w_match    = r_write ? up_wack : up_rack;
   assign w_other    = r_write ? up_rack : up_wack;
   assign w_timeout  = (r_state == ST_WAIT) && !w_match && (r_wait_cnt == c_TMO_LAST);
   // An ack with nobody waiting for it, or of the wrong kind, is stray
   assign w_stray    = w_active ? w_other : (up_wack | up_rack);
   assign w_ok_rdata = r_write ? 32'd0 : up_rdata;

   // Transaction sequencer with all bus and response outputs registered
   always_ff @(posedge up_clk or negedge up_rstn) begin
      if (!up_rstn) begin
         r_state     <= ST_IDLE;
         r_write     <= 1'b0;
         r_wait_cnt  <= '0;
         r_cmd_ready <= 1'b0;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_write <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
         r_up_wreq   <= 1'b0;
         r_up_rreq   <= 1'b0;
         r_up_waddr  <= '0;
         r_up_raddr  <= '0;
         r_up_wdata  <= '0;
      end else begin
         // requests are single-cycle pulses
         r_up_wreq <= 1'b0;
         r_up_rreq <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_cmd_ready <= 1'b1;
               if (cmd_valid && r_cmd_ready) begin
                  r_write     <= cmd_write;
                  r_up_waddr  <= cmd_addr;
                  r_up_raddr  <= cmd_addr;
                  r_up_wdata  <= cmd_wdata;
                  r_up_wreq   <= cmd_write;
                  r_up_rreq   <= ~cmd_write;
                  r_cmd_ready <= 1'b0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_REQ;
               end
            end
            ST_REQ: begin
               r_wait_cnt <= '0;
               if (w_match) begin
                  // responder acked in the request cycle itself
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= r_write;
                  r_rsp_rdata <= w_ok_rdata;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end else begin
                  r_state <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (w_match) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= r_write;
                  r_rsp_rdata <= w_ok_rdata;
                  r_rsp_err   <= 1'b0;
                  r_state     <= ST_RESP;
               end else if (w_timeout) begin
                  r_rsp_valid <= 1'b1;
                  r_rsp_write <= r_write;
                  r_rsp_rdata <= UP_TIMEOUT_DATA;
                  r_rsp_err   <= 1'b1;
                  r_state     <= ST_RESP;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 16'd1;
               end
            end
            ST_RESP: begin
               // response fields hold until the consumer takes them
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_busy      <= 1'b0;
                  r_cmd_ready <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   up_bus_satcnt u_timeout_cnt (
      .i_clk   (up_clk),
      .i_rst_n (up_rstn),
      .i_inc   (w_timeout),
      .o_count (timeout_count)
   );

   up_bus_satcnt u_stray_cnt (
      .i_clk   (up_clk),
      .i_rst_n (up_rstn),
      .i_inc   (w_stray),
      .o_count (stray_ack_count)
   );

   assign cmd_ready = r_cmd_ready;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp_valid;
   assign rsp_write = r_rsp_write;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   assign up_wreq   = r_up_wreq;
   assign up_rreq   = r_up_rreq;
   assign up_waddr  = r_up_waddr;
   assign up_raddr  = r_up_raddr;
   assign up_wdata  = r_up_wdata;

endmodule
`default_nettype wire

// File: tb/tb_up_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_up_bus_master
// Brief    : Self-checking bench for up_bus_master. Expected responses and
//            counter values come from the transaction-level rules: an ack
//            d cycles after the request yields a response at cycle 2+d,
//            no ack yields a timeout response at cycle 2+T.
// Revision : 1.0 - initial release
// ============================================================================
module tb_up_bus_master;
   import up_bus_pkg::*;

   localparam int T  = 8;
   localparam int AW = 9;

   logic          up_clk = 1'b0;
   logic          up_rstn = 1'b0;
   logic          cmd_valid = 1'b0;
   logic          cmd_ready;
   logic          cmd_write = 1'b0;
   logic [AW-1:0] cmd_addr = '0;
   logic [31:0]   cmd_wdata = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic          rsp_write;
   logic [31:0]   rsp_rdata;
   logic          rsp_err;
   logic          up_wreq;
   logic [AW-1:0] up_waddr;
   logic [31:0]   up_wdata;
   logic          up_wack = 1'b0;
   logic          up_rreq;
   logic [AW-1:0] up_raddr;
   logic [31:0]   up_rdata = '0;
   logic          up_rack = 1'b0;
   logic          busy;
   logic [15:0]   timeout_count;
   logic [15:0]   stray_ack_count;

   int n_chk = 0;
   int n_err = 0;
   int exp_stray = 0;
   int exp_to = 0;

   always #5 up_clk = ~up_clk;

   up_bus_master #(.TIMEOUT_CYCLES(T), .ADDR_W(AW)) dut (
      .up_clk          (up_clk),
      .up_rstn         (up_rstn),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_write       (cmd_write),
      .cmd_addr        (cmd_addr),
      .cmd_wdata       (cmd_wdata),
      .rsp_valid       (rsp_valid),
      .rsp_ready       (rsp_ready),
      .rsp_write       (rsp_write),
      .rsp_rdata       (rsp_rdata),
      .rsp_err         (rsp_err),
      .up_wreq         (up_wreq),
      .up_waddr        (up_waddr),
      .up_wdata        (up_wdata),
      .up_wack         (up_wack),
      .up_rreq         (up_rreq),
      .up_raddr        (up_raddr),
      .up_rdata        (up_rdata),
      .up_rack         (up_rack),
      .busy            (busy),
      .timeout_count   (timeout_count),
      .stray_ack_count (stray_ack_count)
   );

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge up_clk);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk_eq({tag, "_ctrl"}, {cmd_ready, rsp_valid, rsp_write, rsp_err, up_wreq, up_rreq, busy}, 64'd0);
      chk_eq({tag, "_data"}, {rsp_rdata, up_wdata}, 64'd0);
      chk_eq({tag, "_addr"}, {up_waddr, up_raddr}, 64'd0);
      chk_eq({tag, "_cnt"}, {timeout_count, stray_ack_count}, 64'd0);
   endtask

   task automatic wait_ready();
      int n = 0;
      while (cmd_ready !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk_eq("cmd_ready_wait", cmd_ready, 1);
   endtask

   // Ack(s) pulsed for one cycle while no transaction is outstanding
   task automatic idle_pulse(input bit w, input bit r);
      up_wack = w;
      up_rack = r;
      tick();
      up_wack = 1'b0;
      up_rack = 1'b0;
      if (w || r) exp_stray++;
      tick();
      chk_eq("idle_stray", stray_ack_count, exp_stray);
   endtask

   // One complete transaction. d: ack delay after the request cycle (-1 = none);
   // wrong_cyc: cycle carrying the other kind of ack (-1 = none);
   // hold: cycles of rsp_ready=0; late_pulse: rack on third hold cycle.
   task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int d, input int wrong_cyc,
                         input int hold, input bit late_pulse);
      int          exp_rsp;
      bit          exp_err;
      logic [31:0] exp_rdata;
      exp_rsp   = (d >= 0 && d <= T) ? 2 + d : 2 + T;
      exp_err   = !(d >= 0 && d <= T);
      exp_rdata = exp_err ? UP_TIMEOUT_DATA : (wr ? 32'd0 : rd);
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = addr;
      cmd_wdata = wd;
      tick();
      cmd_valid = 1'b0;
      cmd_write = 1'($urandom);
      cmd_addr  = AW'($urandom);
      cmd_wdata = $urandom;
      chk_eq("req_wreq", up_wreq, wr);
      chk_eq("req_rreq", up_rreq, !wr);
      chk_eq("req_addr", wr ? up_waddr : up_raddr, addr);
      if (wr) chk_eq("req_wdata", up_wdata, wd);
      chk_eq("req_status", {busy, cmd_ready, rsp_valid}, 64'b100);
      for (int c = 1; c < exp_rsp; c++) begin
         if (!exp_err && c == 1 + d) begin
            if (wr) up_wack = 1'b1;
            else begin
               up_rack  = 1'b1;
               up_rdata = rd;
            end
         end
         if (c == wrong_cyc) begin
            if (wr) up_rack = 1'b1;
            else up_wack = 1'b1;
            exp_stray++;
         end
         tick();
         up_wack  = 1'b0;
         up_rack  = 1'b0;
         up_rdata = $urandom;
         if (c + 1 < exp_rsp) chk_eq("wait_quiet", {rsp_valid, up_wreq, up_rreq}, 64'd0);
      end
      if (exp_err) exp_to++;
      chk_eq("rsp_valid", rsp_valid, 1);
      chk_eq("rsp_write", rsp_write, wr);
      chk_eq("rsp_rdata", rsp_rdata, exp_rdata);
      chk_eq("rsp_err", rsp_err, exp_err);
      chk_eq("rsp_reqs", {up_wreq, up_rreq, cmd_ready}, 64'd0);
      chk_eq("rsp_tmo_cnt", timeout_count, exp_to);
      for (int h = 0; h < hold; h++) begin
         if (late_pulse && h == 2) begin
            up_rack = 1'b1;
            exp_stray++;
         end
         tick();
         up_rack = 1'b0;
         chk_eq("hold_rsp", {rsp_valid, cmd_ready, rsp_write, rsp_err, rsp_rdata},
                {1'b1, 1'b0, wr, exp_err, exp_rdata});
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk_eq("retire", {rsp_valid, cmd_ready, busy}, 64'b010);
      chk_eq("stray_cnt", stray_ack_count, exp_stray);
      chk_eq("tmo_cnt", timeout_count, exp_to);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
      $fatal(1);
   end

   initial begin
      int          d;
      int          wc;
      int          hold;
      int          ers;
      bit          wr;
      // reset state
      #12;
      chk_all_zero("reset");
      @(negedge up_clk);
      up_rstn = 1'b1;

      // directed: write acked at cycle 4, read acked three cycles after request
      do_txn(1'b1, 9'd1, 32'h1e, 32'h0, 3, -1, 0, 1'b0);
      do_txn(1'b0, 9'd0, 32'h0, 32'h00020002, 3, -1, 0, 1'b0);
      // timeout with backpressure and a late read ack at cycle 12
      do_txn(1'b0, 9'd5, 32'h0, 32'h0, -1, -1, 5, 1'b1);
      // stray ack in idle, then wrong-type ack during a read's wait
      idle_pulse(1'b1, 1'b0);
      do_txn(1'b0, 9'd7, 32'h0, 32'hcafef00d, 4, 2, 0, 1'b0);
      idle_pulse(1'b1, 1'b1);
      // boundary ack timing: request cycle itself and last wait cycle
      do_txn(1'b1, 9'h1ff, 32'h12345678, 32'h0, 0, -1, 0, 1'b0);
      do_txn(1'b0, 9'h100, 32'h0, 32'h87654321, 0, -1, 1, 1'b0);
      do_txn(1'b1, 9'h0aa, 32'hffffffff, 32'h0, T, -1, 0, 1'b0);
      do_txn(1'b0, 9'h055, 32'h0, 32'h0badf00d, T, -1, 2, 1'b0);

      // randomized transactions
      for (int i = 0; i < 40; i++) begin
         wr   = 1'($urandom);
         d    = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, T));
         ers  = (d >= 0) ? 2 + d : 2 + T;
         wc   = (ers > 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, ers - 1)) : -1;
         hold = int'($urandom_range(0, 4));
         do_txn(wr, AW'($urandom), $urandom, $urandom, d, wc, hold,
                (hold >= 3) && ($urandom_range(0, 1) == 1));
         if ($urandom_range(0, 3) == 0) idle_pulse(1'($urandom), 1'($urandom));
      end

      // reset during WAIT
      wait_ready();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 9'd3;
      tick();
      cmd_valid = 1'b0;
      tick();
      tick();
      chk_eq("pre_rst_busy", busy, 1);
      #2;
      up_rstn = 1'b0;
      #1;
      chk_all_zero("async_rst");
      @(negedge up_clk);
      @(negedge up_clk);
      up_rstn = 1'b1;
      exp_stray = 0;
      exp_to = 0;
      tick();
      tick();
      chk_eq("post_rst", {cmd_ready, busy, rsp_valid}, 64'b100);
      chk_eq("post_rst_cnt", {timeout_count, stray_ack_count}, 64'd0);
      do_txn(1'b1, 9'd9, 32'h5a5a5a5a, 32'h0, 2, -1, 1, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
